// File: rtl/tile_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tile_spawner
// Description : 2048 post-move stage. Counts the empty cells on a board
//               snapshot and writes a new 2/4 tile into an LFSR-selected
//               empty cell. The optional TILE_SPAWN_DEBUG_EN macro adds
//               ports that load the LFSR directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_spawner #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  FOUR_THR  = 4'd1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef TILE_SPAWN_DEBUG_EN
    input  logic                  dbg_lfsr_load,
    input  logic [15:0]           dbg_lfsr_value,
`endif
    input  logic                  start,
    input  logic                  changed,
    input  logic [3:0][3:0][11:0] matrix_in,
    output logic [3:0][3:0][11:0] matrix_out,
    output logic                  busy,
    output logic                  done,
    output logic                  spawned,
    output logic                  full,
    output logic [1:0]            spawn_row,
    output logic [1:0]            spawn_col
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_REDUCE = 3'd2,
        S_PLACE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] C_TAPS = 16'hB400;

    state_t                  r_state;
    logic [15:0]             r_lfsr;
    logic [7:0]              r_rnd;
    logic [3:0][3:0][11:0]   r_board;
    logic [3:0]              r_k;
    logic [4:0]              r_cnt;
    logic [4:0]              r_tgt;

    logic [15:0]             w_lfsr_adv;
    logic [15:0]             w_lfsr_d;
    logic [7:0]              w_snap;
    logic                    w_cell_empty;
    logic [4:0]              w_cnt_next;
    logic [4:0]              w_tgt_sub;
    logic [4:0]              w_rnd_lo;
    logic [11:0]             w_new_val;
    logic [3:0][3:0][11:0]   w_board_new;

    assign w_lfsr_adv = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? C_TAPS : 16'h0000);

`ifdef TILE_SPAWN_DEBUG_EN
    // A debug load in the start cycle bypasses the LFSR register entirely.
    assign w_lfsr_d = dbg_lfsr_load ? dbg_lfsr_value : w_lfsr_adv;
    assign w_snap   = dbg_lfsr_load ? dbg_lfsr_value[7:0] : r_lfsr[7:0];
`else
    assign w_lfsr_d = w_lfsr_adv;
    assign w_snap   = r_lfsr[7:0];
`endif

    assign w_cell_empty = (r_board[r_k[3:2]][r_k[1:0]] == 12'd0);
    assign w_cnt_next   = r_cnt + {4'd0, w_cell_empty};
    assign w_tgt_sub    = r_tgt - r_cnt;
    assign w_rnd_lo     = {1'b0, r_rnd[3:0]};
    assign w_new_val    = (r_rnd[7:4] < FOUR_THR) ? 12'd4 : 12'd2;

    always_comb begin
        w_board_new = r_board;
        w_board_new[r_k[3:2]][r_k[1:0]] = w_new_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lfsr     <= LFSR_SEED;
            r_rnd      <= 8'd0;
            r_board    <= '0;
            r_k        <= 4'd0;
            r_cnt      <= 5'd0;
            r_tgt      <= 5'd0;
            matrix_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spawned    <= 1'b0;
            full       <= 1'b0;
            spawn_row  <= 2'd0;
            spawn_col  <= 2'd0;
        end else begin
            r_lfsr <= w_lfsr_d;
            done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_board <= matrix_in;
                        r_rnd   <= w_snap;
                        spawned <= 1'b0;
                        full    <= 1'b0;
                        busy    <= 1'b1;
                        r_k     <= 4'd0;
                        r_cnt   <= 5'd0;
                        if (!changed) begin
                            matrix_out <= matrix_in;
                            done       <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    r_cnt <= w_cnt_next;
                    r_k   <= r_k + 4'd1;
                    if (r_k == 4'd15) begin
                        if (w_cnt_next == 5'd0) begin
                            full       <= 1'b1;
                            matrix_out <= r_board;
                            done       <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            // Skip REDUCE when the raw index is already in range.
                            r_tgt   <= w_rnd_lo;
                            r_state <= (w_rnd_lo >= w_cnt_next) ? S_REDUCE : S_PLACE;
                        end
                    end
                end
                S_REDUCE: begin
                    r_tgt <= w_tgt_sub;
                    if (w_tgt_sub < r_cnt) begin
                        r_k     <= 4'd0;
                        r_state <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    r_k <= r_k + 4'd1;
                    if (w_cell_empty) begin
                        if (r_tgt == 5'd0) begin
                            r_board    <= w_board_new;
                            matrix_out <= w_board_new;
                            spawn_row  <= r_k[3:2];
                            spawn_col  <= r_k[1:0];
                            spawned    <= 1'b1;
                            done       <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_tgt <= r_tgt - 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_spawner
// Description : Self-checking bench for tile_spawner; vector table plus
//               hand-written reset and busy-start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_spawner;

    localparam logic [15:0] C_SEED = 16'hACE1;
    localparam logic [3:0]  C_THR  = 4'd1;

    typedef logic [3:0][3:0][11:0] board_t;

    typedef struct {
        logic [15:0] mask;
        logic [11:0] fill;
        logic        chg;
        logic        exp_spawned;
        logic        exp_full;
        bit          poke;
        bit          use_dbg;
        logic [15:0] dbg_val;
    } vec_t;

    typedef struct {
        board_t     mat;
        logic       spawned;
        logic       full;
        logic [1:0] row;
        logic [1:0] col;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        changed;
    board_t      matrix_in;
    board_t      matrix_out;
    logic        busy, done, spawned, full;
    logic [1:0]  spawn_row, spawn_col;
    logic        dbg_lfsr_load;
    logic [15:0] dbg_lfsr_value;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [1:0]  last_row, last_col;
    logic [15:0] m_lfsr;
    vec_t        vecs[9];

    always #5 clk = ~clk;

    tile_spawner #(.LFSR_SEED(C_SEED), .FOUR_THR(C_THR)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef TILE_SPAWN_DEBUG_EN
        .dbg_lfsr_load  (dbg_lfsr_load),
        .dbg_lfsr_value (dbg_lfsr_value),
`endif
        .start          (start),
        .changed        (changed),
        .matrix_in      (matrix_in),
        .matrix_out     (matrix_out),
        .busy           (busy),
        .done           (done),
        .spawned        (spawned),
        .full           (full),
        .spawn_row      (spawn_row),
        .spawn_col      (spawn_col)
    );

    // Reference LFSR: Galois right shift, taps B400, free-running from reset.
    always @(posedge clk or posedge rst) begin
        if (rst)
            m_lfsr <= C_SEED;
`ifdef TILE_SPAWN_DEBUG_EN
        else if (dbg_lfsr_load)
            m_lfsr <= dbg_lfsr_value;
`endif
        else if (m_lfsr[0])
            m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        else
            m_lfsr <= m_lfsr >> 1;
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic board_t mk_board(input logic [15:0] mask, input logic [11:0] fill);
        board_t b;
        for (int k = 0; k < 16; k++)
            b[k / 4][k % 4] = mask[k] ? 12'd0 : fill;
        return b;
    endfunction

    function automatic exp_t model(input board_t b, input logic chg, input logic [15:0] rnd);
        exp_t e;
        int   cnt, tgt, nred, seen;
        e.mat = b; e.spawned = 1'b0; e.full = 1'b0;
        e.row = last_row; e.col = last_col; e.lat = 1;
        if (!chg) return e;
        cnt = 0;
        for (int k = 0; k < 16; k++)
            if (b[k / 4][k % 4] == 12'd0) cnt++;
        if (cnt == 0) begin
            e.full = 1'b1;
            e.lat  = 17;
            return e;
        end
        tgt  = int'(rnd[3:0]) % cnt;
        nred = int'(rnd[3:0]) / cnt;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (b[k / 4][k % 4] == 12'd0) begin
                if (seen == tgt) begin
                    e.mat[k / 4][k % 4] = (rnd[7:4] < C_THR) ? 12'd4 : 12'd2;
                    e.spawned = 1'b1;
                    e.row = 2'(k / 4);
                    e.col = 2'(k % 4);
                    e.lat = 16 + nred + k + 2;
                    break;
                end
                seen++;
            end
        end
        return e;
    endfunction

    task automatic run_case(input vec_t v);
        exp_t        e, got;
        int          cyc, extra;
        logic [15:0] rnd;
        board_t      b;
        b = mk_board(v.mask, v.fill);
        @(negedge clk);
        matrix_in = b;
        changed   = v.chg;
        start     = 1'b1;
        rnd       = m_lfsr;
        if (v.use_dbg) begin
            dbg_lfsr_load  = 1'b1;
            dbg_lfsr_value = v.dbg_val;
            rnd            = v.dbg_val;
        end
        e = model(b, v.chg, rnd);
        q.push_back(e);
        if (e.spawned) begin
            last_row = e.row;
            last_col = e.col;
        end
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            dbg_lfsr_load = 1'b0;
            matrix_in     = '1;
            changed       = ~v.chg;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (done || cyc >= 60) break;
            start = v.poke && (cyc >= 2) && (cyc <= 4);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (done) begin
            got = q.pop_front();
            check("matrix_out", matrix_out, got.mat);
            check("spawned", spawned, v.exp_spawned);
            check("full", full, v.exp_full);
            check("spawn_row", spawn_row, got.row);
            check("spawn_col", spawn_col, got.col);
            check("latency", cyc, got.lat);
        end
        @(negedge clk);
        check("done_width", done, 0);
        check("busy_idle", busy, 0);
        if (v.poke) begin
            extra = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_second_done", extra, 0);
        end
    endtask

    initial begin
        vec_t d;
        int   cyc, seen;

        //           mask      fill    chg   spw   full  poke dbg dbgval
        vecs[0] = '{16'h0200, 12'd2,  1'b1, 1'b1, 1'b0, 0, 0, 16'h0};
        vecs[1] = '{16'h0000, 12'd8,  1'b1, 1'b0, 1'b1, 0, 0, 16'h0};
        vecs[2] = '{16'hFFFF, 12'd2,  1'b0, 1'b0, 1'b0, 0, 0, 16'h0};
        vecs[3] = '{16'hFFFF, 12'd2,  1'b1, 1'b1, 1'b0, 0, 0, 16'h0};
        vecs[4] = '{16'h8001, 12'd16, 1'b1, 1'b1, 1'b0, 1, 0, 16'h0};
        vecs[5] = '{16'h5A5A, 12'd32, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0};
        vecs[6] = '{16'h8000, 12'd4,  1'b1, 1'b1, 1'b0, 0, 0, 16'h0};
        vecs[7] = '{16'h00F0, 12'd2,  1'b0, 1'b0, 1'b0, 0, 0, 16'h0};
        vecs[8] = '{16'h0000, 12'd64, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0};

        rst = 1'b1; start = 1'b0; changed = 1'b0; matrix_in = '0;
        dbg_lfsr_load = 1'b0; dbg_lfsr_value = 16'h0;
        last_row = 2'd0; last_col = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_matrix", matrix_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spawned", spawned, 0);
        check("rst_full", full, 0);
        check("rst_row", spawn_row, 0);
        check("rst_col", spawn_col, 0);

        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_case(vecs[i]);
        end

`ifdef TILE_SPAWN_DEBUG_EN
        d = '{16'hFFFF, 12'd2, 1'b1, 1'b1, 1'b0, 0, 1, 16'h0005};
        run_case(d);
        check("t4_cell", matrix_out[1][1], 12'd4);
        d = '{16'h8009, 12'd8, 1'b1, 1'b1, 1'b0, 0, 1, 16'h0017};
        run_case(d);
        check("t5_cell", matrix_out[0][3], 12'd2);
`endif

        // Reset while PLACE is scanning towards the only empty cell.
        @(negedge clk);
        matrix_in = mk_board(16'h8000, 12'd2);
        changed   = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_matrix", matrix_out, 0);
        check("rst_mid_done", done, 0);
        rst = 1'b0;
        last_row = 2'd0;
        last_col = 2'd0;
        seen = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rst_no_done", seen, 0);
        check("rst_spawned_clr", spawned, 0);

        run_case(vecs[4]);
        run_case(vecs[0]);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
